// File: rtl/data_memory_ctrl.sv
// Data memory for the ARM cores with a req/ready handshake and a configurable
// number of wait states. Byte, halfword and word accesses; loads zero- or
// sign-extend. Misaligned, out-of-range and reserved-size accesses are
// rejected with fault instead of touching the array.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   req       access request, sampled only in IDLE
//   WE        1 = store, 0 = load
//   size      00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   sign_ext  loads only: 1 = sign-extend, 0 = zero-extend
//   addr      byte address
//   WD        store data (low byte/halfword used for narrow stores)
//   RD        registered load result
//   ready     one-cycle response strobe
//   fault     access rejected, valid only with ready
module data_memory_ctrl #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        WE,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        ready,
  output logic        fault
);

  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_STATES - 1);
  localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wd_q;
  logic            we_q, sext_q, fault_q;
  logic [1:0]      size_q;
  logic [31:0]     rd_q, rd_d;
  logic            enter_resp;

  logic [31:0]     mem [DEPTH];

  // Access attributes: straight from the inputs while accepting (needed when
  // WAIT_STATES = 0 and the commit coincides with acceptance), else latched.
  logic            idle, req_fault;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wd;
  logic            acc_we, acc_sext, acc_fault;
  logic [1:0]      acc_size;
  logic [AW-1:0]   idx;

  assign idle      = (state_q == StIdle);
  assign acc_addr  = idle ? addr[AW+1:0] : addr_q;
  assign acc_wd    = idle ? WD : wd_q;
  assign acc_we    = idle ? WE : we_q;
  assign acc_sext  = idle ? sign_ext : sext_q;
  assign acc_size  = idle ? size : size_q;
  assign acc_fault = idle ? req_fault : fault_q;
  assign idx       = acc_addr[AW+1:2];

  always_comb begin
    req_fault = 1'b0;
    case (size)
      2'b00:   req_fault = 1'b0;
      2'b01:   req_fault = addr[0];
      2'b10:   req_fault = |addr[1:0];
      default: req_fault = 1'b1;
    endcase
    if (addr[31:2] >= DEPTH_W) req_fault = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d = '0;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == LAST_CNT) begin
          state_d    = StResp;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Load extraction and lane selection for stores.
  logic [31:0] word, shifted, load_val, wdata;
  logic [15:0] half;
  logic [3:0]  be;

  always_comb begin
    word     = mem[idx];
    shifted  = word >> {acc_addr[1:0], 3'b000};
    half     = acc_addr[1] ? word[31:16] : word[15:0];
    load_val = word;
    be       = 4'b0000;
    wdata    = acc_wd;
    case (acc_size)
      2'b00: begin
        load_val = {{24{acc_sext & shifted[7]}}, shifted[7:0]};
        be       = 4'b0001 << acc_addr[1:0];
        wdata    = {4{acc_wd[7:0]}};
      end
      2'b01: begin
        load_val = {{16{acc_sext & half[15]}}, half};
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{acc_wd[15:0]}};
      end
      2'b10: begin
        load_val = word;
        be       = 4'b1111;
      end
      default: begin
        load_val = word;
        be       = 4'b0000;
      end
    endcase
  end

  always_comb begin
    if (acc_fault)   rd_d = '0;
    else if (acc_we) rd_d = rd_q;
    else             rd_d = load_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      fault_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req) begin
        addr_q  <= addr[AW+1:0];
        wd_q    <= WD;
        we_q    <= WE;
        sext_q  <= sign_ext;
        size_q  <= size;
        fault_q <= req_fault;
      end
      if (enter_resp) rd_q <= rd_d;
    end
  end

  // Array is deliberately not reset; a reset mid-access never reaches here
  // because the commit only happens on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign RD    = rd_q;
  assign ready = (state_q == StResp);
  assign fault = ready & fault_q;

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised data memory for the ARM cores.
- Supports byte, halfword and word loads/stores with zero- or sign-extension.
- Uses a req/ready handshake with a configurable number of wait states, so the pipelined and multicycle datapaths can stall on memory.
- Detects misaligned and out-of-range accesses and reports them as a fault instead of corrupting memory.

Parameters:
- DEPTH, 64, number of 32-bit words in the array; any value ≥ 1.
- WAIT_STATES, 1, extra cycles between request acceptance and response; any value ≥ 0.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request; sampled only in IDLE.
- WE  input  1  1 = store, 0 = load.
- size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as fault).
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  32  byte address.
- WD  input  32  store data; byte/halfword taken from WD[7:0]/WD[15:0].
- RD  output  32  load result, registered.
- ready  output  1  one-cycle response strobe.
- fault  output  1  valid with ready; 1 = access rejected.

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Reset state:
  - FSM goes to IDLE; RD = 0, ready = 0, fault = 0; wait counter = 0.
  - Memory array is not reset; contents are undefined until written.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on a rising edge with req = 1, latch addr, WD, WE, size, sign_ext and the fault check result. Go to WAIT if WAIT_STATES > 0, else go straight to RESP.
  - WAIT: counter counts WAIT_STATES cycles (width clog2(WAIT_STATES+1), minimum 1 bit), then go to RESP.
  - RESP: ready = 1 for exactly one cycle, then unconditional return to IDLE. req is ignored in WAIT and RESP.
- Latency: req accepted at edge N gives ready = 1 in the cycle after edge N + WAIT_STATES. Throughput is one access per WAIT_STATES + 2 cycles.
- Requester rules:
  - Hold req and the inputs stable until ready; the latched copies are authoritative anyway.
  - Drop req in the ready cycle. If req is still 1 in the following IDLE cycle, a new access starts.
- Fault conditions, evaluated at acceptance:
  - size = 11.
  - size = 01 with addr[0] ≠ 0.
  - size = 10 with addr[1:0] ≠ 00.
  - addr[31:2] ≥ DEPTH.
- Faulted access: no memory write; RD loads 0; fault = 1 with ready.
- Store commit: happens on the edge entering RESP, only if not faulted. Only the addressed lanes change (little-endian):
  - byte: lane addr[1:0] ← WD[7:0].
  - halfword: lanes {addr[1],0} and {addr[1],1} ← WD[15:0].
  - word: all four lanes.
- Store response: RD holds its previous value; fault = 0.
- Load: on the edge entering RESP, RD ← the extracted lane(s), extended per sign_ext. Word loads ignore sign_ext.
- Output hold: RD holds its value until the next completed load or faulted access. fault is meaningful only while ready = 1 and is 0 otherwise.
- Reset mid-operation: asserting reset in WAIT aborts the access. An uncommitted store is never written; no ready pulse follows.
- Read-after-write: a load accepted after a store's ready returns the stored data. No forwarding is needed because accesses are serialised.

Test Plan:
- Word round trip (WAIT_STATES = 1): store 0xDEADBEEF to addr 0x10, then load word 0x10 → RD = 0xDEADBEEF, fault = 0. ready rises 2 cycles after acceptance.
- Byte/halfword lanes: word 0x00000000 at 0x20.
  - Store byte 0x80 to 0x23 and halfword 0x1234 to 0x20.
  - Load word → 0x80001234.
  - Load byte 0x23, sign_ext = 1 → 0xFFFFFF80; sign_ext = 0 → 0x00000080.
- Halfword sign extension: store half 0xF00D at 0x32, load half 0x32 with sign_ext = 1 → 0xFFFFF00D. Lanes 0x30–0x31 unchanged.
- Faults:
  - Word store to 0x06 → ready with fault = 1, RD = 0, word at 0x04 unchanged.
  - Half load from 0x41 → fault = 1.
  - Word access at addr 4*DEPTH (0x100 for DEPTH = 64) → fault = 1.
  - size = 11 → fault = 1.
- Timing sweep: WAIT_STATES = 0 and WAIT_STATES = 3.
  - ready appears 1 and 4 cycles after acceptance respectively.
  - req held high through RESP restarts exactly one cycle after ready.
  - req toggled during WAIT has no effect.
- Reset abort: WAIT_STATES = 3, store 0xCAFEF00D to 0x08 with a prior value of 0x11111111. Pulse reset in the 2nd WAIT cycle → ready never rises, RD = 0, and a later load of 0x08 returns 0x11111111.
